// File: rtl/apb_master_bridge_if.sv
// -----------------------------------------------------------------------------
// apb_master_bridge_if
// Bundles the command, response and APB bus signals of the APB master bridge.
//   command : cmd_valid, cmd_ready, cmd_addr, cmd_write, cmd_wdata
//   response: rsp_valid, rsp_ready, rsp_rdata, rsp_err, rsp_timeout
//   APB     : psel, penable, pwrite, paddr, pwdata, prdata, pready, pslverr
// Modports:
//   master - the bridge itself (drives cmd_ready, rsp_*, APB requests)
//   slave  - the environment around the bridge (requester, consumer, APB slave)
// -----------------------------------------------------------------------------
interface apb_master_bridge_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [ADDR_WIDTH-1:0] cmd_addr;
    logic                  cmd_write;
    logic [DATA_WIDTH-1:0] cmd_wdata;

    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_WIDTH-1:0] rsp_rdata;
    logic                  rsp_err;
    logic                  rsp_timeout;

    logic                  psel;
    logic                  penable;
    logic                  pwrite;
    logic [ADDR_WIDTH-1:0] paddr;
    logic [DATA_WIDTH-1:0] pwdata;
    logic [DATA_WIDTH-1:0] prdata;
    logic                  pready;
    logic                  pslverr;

    modport master (
        input  cmd_valid, cmd_addr, cmd_write, cmd_wdata, rsp_ready,
               prdata, pready, pslverr,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
               psel, penable, pwrite, paddr, pwdata
    );

    modport slave (
        output cmd_valid, cmd_addr, cmd_write, cmd_wdata, rsp_ready,
               prdata, pready, pslverr,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
               psel, penable, pwrite, paddr, pwdata
    );
endinterface

// File: rtl/apb_master_bridge.sv
// -----------------------------------------------------------------------------
// apb_master_bridge
// Turns a valid/ready command into a single APB transfer and returns the
// outcome on a valid/ready response channel. An ACCESS phase that sees no
// pready for TIMEOUT cycles is aborted and reported as an error + timeout.
// Ports:
//   pclk    - clock, rising edge
//   presetn - asynchronous active-low reset
//   bus     - apb_master_bridge_if.master (command, response and APB signals)
// -----------------------------------------------------------------------------
module apb_master_bridge #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int TIMEOUT    = 15   // 1..255
) (
    input  logic                   pclk,
    input  logic                   presetn,
    apb_master_bridge_if.master    bus
);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_e;

    localparam logic [7:0] TIMEOUT_LIM = 8'(TIMEOUT);

    state_e                state_q;
    logic                  cmd_ready_q;
    logic                  psel_q;
    logic                  penable_q;
    logic                  pwrite_q;
    logic [ADDR_WIDTH-1:0] paddr_q;
    logic [DATA_WIDTH-1:0] pwdata_q;
    logic                  rsp_valid_q;
    logic [DATA_WIDTH-1:0] rsp_rdata_q;
    logic                  rsp_err_q;
    logic                  rsp_timeout_q;
    logic [7:0]            wait_cnt_q;   // ACCESS cycles seen with pready low

    // NOTE: every register here uses non-blocking assignments so all state
    // updates on an edge see the pre-edge values of the others; the reset
    // branch is asynchronous, so presetn clears outputs without a clock.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state_q       <= IDLE;
            cmd_ready_q   <= 1'b0;
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            pwrite_q      <= 1'b0;
            paddr_q       <= '0;
            pwdata_q      <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_err_q     <= 1'b0;
            rsp_timeout_q <= 1'b0;
            wait_cnt_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    // cmd_ready is low for the first cycle after reset, so
                    // acceptance keys off the registered ready, not the state.
                    cmd_ready_q <= 1'b1;
                    if (bus.cmd_valid && cmd_ready_q) begin
                        paddr_q     <= bus.cmd_addr;
                        pwrite_q    <= bus.cmd_write;
                        pwdata_q    <= bus.cmd_wdata;
                        psel_q      <= 1'b1;
                        penable_q   <= 1'b0;
                        cmd_ready_q <= 1'b0;
                        state_q     <= SETUP;
                    end
                end
                SETUP: begin
                    penable_q  <= 1'b1;
                    wait_cnt_q <= '0;
                    state_q    <= ACCESS;
                end
                ACCESS: begin
                    if (bus.pready) begin
                        // Completion beats a timeout landing on the same edge.
                        rsp_rdata_q   <= pwrite_q ? '0 : bus.prdata;
                        rsp_err_q     <= bus.pslverr;
                        rsp_timeout_q <= 1'b0;
                        psel_q        <= 1'b0;
                        penable_q     <= 1'b0;
                        rsp_valid_q   <= 1'b1;
                        state_q       <= RESP;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + 8'd1;
                        if (wait_cnt_q + 8'd1 == TIMEOUT_LIM) begin
                            rsp_rdata_q   <= '0;
                            rsp_err_q     <= 1'b1;
                            rsp_timeout_q <= 1'b1;
                            psel_q        <= 1'b0;
                            penable_q     <= 1'b0;
                            rsp_valid_q   <= 1'b1;
                            state_q       <= RESP;
                        end
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        cmd_ready_q <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.cmd_ready   = cmd_ready_q;
    assign bus.psel        = psel_q;
    assign bus.penable     = penable_q;
    assign bus.pwrite      = pwrite_q;
    assign bus.paddr       = paddr_q;
    assign bus.pwdata      = pwdata_q;
    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_rdata   = rsp_rdata_q;
    assign bus.rsp_err     = rsp_err_q;
    assign bus.rsp_timeout = rsp_timeout_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
// -----------------------------------------------------------------------------
// tb_apb_master_bridge
// Self-checking bench for apb_master_bridge. The bench plays requester,
// response consumer and APB slave. Expected outcomes come from a transaction
// level model: a transfer with W wait states completes after W+1 ACCESS
// cycles unless W >= TIMEOUT, in which case it aborts after TIMEOUT cycles.
// -----------------------------------------------------------------------------
module tb_apb_master_bridge;

    localparam int DW      = 32;
    localparam int AW      = 32;
    localparam int TIMEOUT = 15;

    logic pclk;
    logic presetn;
    int   n_checks = 0;
    int   n_errors = 0;

    apb_master_bridge_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    apb_master_bridge #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .TIMEOUT    (TIMEOUT)
    ) dut (
        .pclk    (pclk),
        .presetn (presetn),
        .bus     (bus.master)
    );

    initial begin
        pclk = 1'b0;
        forever #5 pclk = ~pclk;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // penable must never be seen without psel.
    always @(negedge pclk) begin
        if (presetn === 1'b1)
            check("penable_without_psel", 64'(bus.penable & ~bus.psel), 64'd0);
    end

    // One complete transfer, starting and ending on a falling edge.
    task automatic run_txn(input logic [31:0] addr, input logic wr, input logic [31:0] wdata,
                           input int waits, input logic [31:0] rdata, input logic slverr,
                           input int rsp_delay);
        int          n;
        bit          exp_to;
        int          exp_acc;
        logic [31:0] exp_rd;
        logic        exp_err;

        // Reference outcome of the transfer.
        exp_to  = (waits >= TIMEOUT);
        exp_acc = exp_to ? TIMEOUT : waits + 1;
        exp_rd  = (exp_to || wr) ? 32'd0 : rdata;
        exp_err = exp_to ? 1'b1 : slverr;

        n = 0;
        while (bus.cmd_ready !== 1'b1 && n < 50) begin
            @(negedge pclk);
            n++;
        end
        check("cmd_ready_idle", 64'(bus.cmd_ready), 64'd1);

        bus.cmd_addr  = addr;
        bus.cmd_write = wr;
        bus.cmd_wdata = wdata;
        bus.cmd_valid = 1'b1;
        @(posedge pclk);
        @(negedge pclk);
        // Scramble the command fields: the bridge must hold its own copy.
        bus.cmd_valid = 1'b0;
        bus.cmd_addr  = $urandom;
        bus.cmd_write = 1'($urandom);
        bus.cmd_wdata = $urandom;

        check("setup_ctl", 64'({bus.psel, bus.penable, bus.cmd_ready, bus.rsp_valid}), 64'(4'b1000));
        check("setup_paddr", 64'(bus.paddr), 64'(addr));
        check("setup_pwrite", 64'(bus.pwrite), 64'(wr));
        check("setup_pwdata", 64'(bus.pwdata), 64'(wdata));

        @(negedge pclk);
        n = 0;
        while (n < 300) begin
            check("access_ctl", 64'({bus.psel, bus.penable, bus.pwrite}), 64'({2'b11, wr}));
            check("access_pwdata", 64'(bus.pwdata), 64'(wdata));
            bus.pready  = (n == waits);
            bus.prdata  = (n == waits) ? rdata : $urandom;
            bus.pslverr = (n == waits) ? slverr : 1'($urandom);
            @(posedge pclk);
            @(negedge pclk);
            n++;
            if (bus.rsp_valid === 1'b1) break;
        end
        // Noise on the slave response outside ACCESS must be ignored.
        bus.pready  = 1'b0;
        bus.prdata  = $urandom;
        bus.pslverr = 1'($urandom);

        check("access_cycles", 64'(n), 64'(exp_acc));
        check("rsp_valid", 64'(bus.rsp_valid), 64'd1);
        check("rsp_rdata", 64'(bus.rsp_rdata), 64'(exp_rd));
        check("rsp_err", 64'(bus.rsp_err), 64'(exp_err));
        check("rsp_timeout", 64'(bus.rsp_timeout), 64'(exp_to));
        check("resp_bus_idle", 64'({bus.psel, bus.penable, bus.cmd_ready}), 64'd0);

        for (int i = 0; i < rsp_delay; i++) begin
            bus.rsp_ready = 1'b0;
            @(negedge pclk);
            check("hold_rsp", 64'({bus.rsp_valid, bus.rsp_err, bus.rsp_timeout, bus.rsp_rdata}),
                  64'({1'b1, exp_err, exp_to, exp_rd}));
            check("hold_ctl", 64'({bus.cmd_ready, bus.psel, bus.penable}), 64'd0);
            check("hold_paddr", 64'(bus.paddr), 64'(addr));
        end

        bus.rsp_ready = 1'b1;
        @(posedge pclk);
        @(negedge pclk);
        bus.rsp_ready = 1'b0;
        check("post_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        check("post_cmd_ready", 64'(bus.cmd_ready), 64'd1);
        check("post_pwdata", 64'(bus.pwdata), 64'(wdata));
    endtask

    initial begin
        presetn       = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.cmd_addr  = '0;
        bus.cmd_write = 1'b0;
        bus.cmd_wdata = '0;
        bus.rsp_ready = 1'b0;
        bus.prdata    = '0;
        bus.pready    = 1'b0;
        bus.pslverr   = 1'b0;

        // Reset state, with the clock running.
        #2;
        check("rst_ctl", 64'({bus.cmd_ready, bus.psel, bus.penable, bus.pwrite, bus.rsp_valid,
                              bus.rsp_err, bus.rsp_timeout}), 64'd0);
        repeat (2) @(negedge pclk);
        check("rst_data", 64'({bus.paddr, bus.pwdata}), 64'd0);
        check("rst_rdata", 64'(bus.rsp_rdata), 64'd0);
        check("rst_cmd_ready", 64'(bus.cmd_ready), 64'd0);
        presetn = 1'b1;
        #1;
        check("release_cmd_ready_low", 64'(bus.cmd_ready), 64'd0);
        @(negedge pclk);
        check("release_cmd_ready_high", 64'(bus.cmd_ready), 64'd1);

        // Directed cases.
        run_txn(32'h04, 1'b1, 32'hDEAD_BEEF, 0, 32'h0, 1'b0, 0);          // zero-wait write
        run_txn(32'h04, 1'b0, 32'h0, 3, 32'h1234_5678, 1'b0, 0);          // 3-wait read
        run_txn(32'h08, 1'b1, 32'hCAFE_F00D, 1, 32'h0, 1'b1, 0);          // slave error
        run_txn(32'h0C, 1'b0, 32'h0, 40, 32'hAAAA_5555, 1'b0, 1);         // timeout read
        run_txn(32'h10, 1'b0, 32'h0, TIMEOUT - 1, 32'h5A5A_A5A5, 1'b0, 0); // ready on last cycle
        run_txn(32'h14, 1'b1, 32'h0BAD_CAFE, TIMEOUT, 32'h0, 1'b0, 0);     // timeout write
        run_txn(32'h18, 1'b0, 32'h0, 2, 32'h8765_4321, 1'b1, 5);          // slow consumer
        run_txn(32'h1C, 1'b1, 32'h1111_2222, 0, 32'h0, 1'b0, 0);          // back-to-back

        // Reset during ACCESS aborts with no response afterwards.
        bus.cmd_addr  = 32'h20;
        bus.cmd_write = 1'b0;
        bus.cmd_wdata = 32'h0;
        bus.cmd_valid = 1'b1;
        @(posedge pclk);
        @(negedge pclk);
        bus.cmd_valid = 1'b0;
        @(negedge pclk);
        check("mid_access_ctl", 64'({bus.psel, bus.penable}), 64'(2'b11));
        #2 presetn = 1'b0;
        #1;
        check("mid_rst_ctl", 64'({bus.psel, bus.penable, bus.rsp_valid, bus.cmd_ready}), 64'd0);
        check("mid_rst_paddr", 64'(bus.paddr), 64'd0);
        @(negedge pclk);
        presetn    = 1'b1;
        bus.pready = 1'b1;
        bus.prdata = 32'h3333_4444;
        for (int i = 0; i < 4; i++) begin
            @(negedge pclk);
            check("post_rst_no_rsp", 64'({bus.rsp_valid, bus.psel, bus.penable}), 64'd0);
        end
        bus.pready = 1'b0;
        check("post_rst_cmd_ready", 64'(bus.cmd_ready), 64'd1);

        // Randomized transfers against the reference model.
        for (int k = 0; k < 25; k++) begin
            run_txn($urandom, 1'($urandom), $urandom, int'($urandom_range(0, TIMEOUT + 2)),
                    $urandom, 1'($urandom), int'($urandom_range(0, 3)));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/apb_master_bridge.md
APB_MASTER_BRIDGE -- requirements
Module: apb_master_bridge

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, APB data width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 32, APB address width.
REQ-003 SHALL have parameter TIMEOUT, default 15, max ACCESS cycles waiting for pready (range 1..255).
REQ-004 SHALL have port pclk  input  1  clock; all logic on rising edge.
REQ-005 SHALL have port presetn  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port cmd_valid  input  1  command request.
REQ-007 SHALL have port cmd_ready  output  1  bridge can accept a command.
REQ-008 SHALL have port cmd_addr  input  ADDR_WIDTH  transfer address.
REQ-009 SHALL have port cmd_write  input  1  1 = write, 0 = read.
REQ-010 SHALL have port cmd_wdata  input  DATA_WIDTH  write data.
REQ-011 SHALL have port rsp_valid  output  1  response available.
REQ-012 SHALL have port rsp_ready  input  1  response consumer ready.
REQ-013 SHALL have port rsp_rdata  output  DATA_WIDTH  read data (0 for writes and timeouts).
REQ-014 SHALL have port rsp_err  output  1  pslverr sampled or timeout.
REQ-015 SHALL have port rsp_timeout  output  1  transfer aborted by timeout.
REQ-016 SHALL have ports psel, penable, pwrite  output  1 each  APB control.
REQ-017 SHALL have ports paddr  output  ADDR_WIDTH, pwdata  output  DATA_WIDTH  APB address/data.
REQ-018 SHALL have ports prdata  input  DATA_WIDTH, pready  input  1, pslverr  input  1  APB slave response.

Function
REQ-019 SHALL implement FSM states IDLE, SETUP, ACCESS, RESP; all outputs registered.
REQ-020 cmd_ready SHALL be 1 only in IDLE; a command is accepted on a clock edge with cmd_valid && cmd_ready.
REQ-021 On acceptance SHALL latch addr/write/wdata into paddr/pwrite/pwdata and go to SETUP; these SHALL stay stable until the return to IDLE.
REQ-022 SETUP: psel=1, penable=0, exactly one cycle, then ACCESS.
REQ-023 ACCESS: psel=1, penable=1; pready sampled each edge; wait states unlimited up to TIMEOUT.
REQ-024 On an ACCESS edge with pready=1: capture prdata (reads only, else 0) into rsp_rdata, pslverr into rsp_err, set rsp_timeout=0, drop psel/penable, go to RESP.
REQ-025 Timeout counter SHALL clear on entering ACCESS and increment each ACCESS cycle with pready=0; when count reaches TIMEOUT with pready still 0, drop psel/penable, set rsp_err=1, rsp_timeout=1, rsp_rdata=0, go to RESP.
REQ-026 pready=1 on the same edge the count reaches TIMEOUT SHALL win: normal completion, no timeout.
REQ-027 Minimum latency: accept edge T, SETUP cycle T..T+1, ACCESS T+1..T+2, rsp_valid=1 from T+2 with zero wait states.
REQ-028 RESP: rsp_valid=1, psel=0, penable=0; rsp_* held stable until rsp_ready=1, then go to IDLE (rsp_valid=0 next cycle).
REQ-029 Back-to-back: next command acceptable the cycle after response handshake; no APB idle cycle shorter than one (IDLE always visited).
REQ-030 pslverr and prdata SHALL be ignored outside ACCESS-with-pready.
REQ-031 penable SHALL never be 1 while psel is 0.

Reset
REQ-032 presetn=0 SHALL asynchronously force state IDLE, psel=0, penable=0, pwrite=0, paddr=0, pwdata=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, rsp_timeout=0, counter=0; cmd_ready=0 during reset, 1 from first edge after release.
REQ-033 Reset mid-transfer SHALL abort with no response generated after release.

Verification
REQ-034 Write addr=0x04 data=0xDEADBEEF, pready=1 immediately -> psel rise T+1... rsp_valid at T+2, rsp_err=0, rsp_timeout=0, pwdata=0xDEADBEEF throughout.
REQ-035 Read addr=0x04, 3 wait states, prdata=0x12345678 with pready -> rsp_rdata=0x12345678, ACCESS lasts 4 cycles, rsp_err=0.
REQ-036 Write with pslverr=1 on completion -> rsp_err=1, rsp_timeout=0.
REQ-037 pready held 0, TIMEOUT=15 -> abort after 15 ACCESS cycles, rsp_err=1, rsp_timeout=1, rsp_rdata=0; pready=1 on cycle 15 -> normal completion.
REQ-038 rsp_ready held 0 for 5 cycles -> rsp_* stable, cmd_ready=0, psel=0; second command accepted cycle after handshake.
REQ-039 presetn asserted during ACCESS -> psel/penable=0 immediately, no rsp_valid after release.
